// File: rtl/cpu_run_controller.sv
// cpu_run_controller: front-panel run/step controller that debounces panel inputs and drives the CAR enables
module cpu_run_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_start,
    input  logic             i_btn_step,
    input  logic             i_sw_step_mode,
    input  logic             i_halt,
    input  logic [6:0]       i_car_data,
    output logic             o_cpu_start,
    output logic             o_step_execution,
    output logic             o_next_instr_stimulus,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_instr_count,
    output logic [1:0]       o_state
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ARMED = 2'd2, HALTED = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [2:0]       raw, sync1_q, sync2_q, stable_q, stable_prev_q, press;
    logic [DB_W-1:0]  db_cnt_q [3];
    logic [6:0]       car_prev_q;
    logic             cpu_start_d, step_exec_d, stim_d, halted_d, fetch, start_p, step_p;
    logic             cpu_start_q, step_exec_q, stim_q, halted_q;
    logic [CNT_W-1:0] count_q, count_d;

    // bit 0 start button, bit 1 step button, bit 2 mode switch
    assign raw     = {i_sw_step_mode, i_btn_step, i_btn_start};
    assign press   = stable_q & ~stable_prev_q;
    assign start_p = press[0];
    assign step_p  = press[1];
    assign fetch   = cpu_start_q && i_car_data == 7'h00 && car_prev_q != 7'h00;

    // Synchronise each input, accept a new level only after DEBOUNCE_CYCLES disagreeing samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int k = 0; k < 3; k++) begin
                if (sync2_q[k] == stable_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    stable_q[k] <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Next state: halt beats start beats step; a step coinciding with start is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_p) state_d = RUN;
            RUN:     state_d = i_halt ? HALTED : start_p ? IDLE : (step_p && step_exec_q) ? ARMED : RUN;
            ARMED:   state_d = i_halt ? HALTED : start_p ? IDLE : fetch ? RUN : ARMED;
            HALTED:  if (start_p) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cpu_start_d = state_d != IDLE;
        stim_d      = state_d == ARMED;
        halted_d    = state_d == HALTED;
        step_exec_d = (state_d == IDLE) ? 1'b0 : (state_q == IDLE) ? stable_q[2] : step_exec_q;
        count_d     = (state_q == IDLE && state_d == RUN) ? '0 : fetch ? count_q + 1'b1 : count_q;
    end

    // State, registered outputs and CAR history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cpu_start_q <= 1'b0;
            step_exec_q <= 1'b0;
            stim_q      <= 1'b0;
            halted_q    <= 1'b0;
            count_q     <= '0;
            car_prev_q  <= 7'h20;
        end else begin
            state_q     <= state_d;
            cpu_start_q <= cpu_start_d;
            step_exec_q <= step_exec_d;
            stim_q      <= stim_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
            car_prev_q  <= i_car_data;
        end
    end

    assign o_cpu_start           = cpu_start_q;
    assign o_step_execution      = step_exec_q;
    assign o_next_instr_stimulus = stim_q;
    assign o_halted              = halted_q;
    assign o_instr_count         = count_q;
    assign o_state               = state_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed scenarios plus randomized operations against a rule-level model
module tb_cpu_run_controller;
    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          btn_start = 1'b0, btn_step = 1'b0, sw = 1'b0, halt = 1'b0;
    logic [6:0]    car = 7'h20;
    logic          cpu_start, step_exec, stim, halted;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [9:0]    obs;
    int            tests = 0, fails = 0;

    cpu_run_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_start(btn_start), .i_btn_step(btn_step),
        .i_sw_step_mode(sw), .i_halt(halt), .i_car_data(car),
        .o_cpu_start(cpu_start), .o_step_execution(step_exec), .o_next_instr_stimulus(stim),
        .o_halted(halted), .o_instr_count(count), .o_state(state)
    );

    always #5 clk = ~clk;

    assign obs = {cpu_start, step_exec, stim, halted, state, count};

    // Expected output vector derived from the abstract run state
    function automatic logic [9:0] expect_of(input int s, input bit se, input int c);
        logic [1:0] sv = 2'(s);
        logic [3:0] cv = 4'(c % 16);
        return {s != 0, se, s == 2, s == 3, sv, cv};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit p);
        btn_start = s;
        btn_step  = p;
        tick(10);
        btn_start = 1'b0;
        btn_step  = 1'b0;
        tick(10);
    endtask

    task automatic fetch_once();
        car = 7'h00;
        tick(1);
        car = 7'h20;
        tick(1);
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (obs !== 10'd0) begin fails++; $display("FAIL reset_hold: got %h want %h", obs, 10'd0); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        tests++;
        if (obs !== 10'd0) begin fails++; $display("FAIL reset_release: got %h want %h", obs, 10'd0); end
    endtask

    task automatic test_debounce();
        btn_start = 1'b1;
        tick(2);
        btn_start = 1'b0;
        tick(12);
        tests++;
        if (obs !== expect_of(0, 0, 0)) begin fails++; $display("FAIL bounce_ignored: got %h want %h", obs, expect_of(0, 0, 0)); end
        btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            tests++;
            if (cpu_start !== (k >= 7)) begin fails++; $display("FAIL start_latency k=%0d: got %b want %b", k, cpu_start, k >= 7); end
        end
        btn_start = 1'b0;
        tick(10);
    endtask

    task automatic test_auto_fetch();
        logic [6:0] seq [6] = '{7'h20, 7'h00, 7'h01, 7'h0B, 7'h00, 7'h01};
        for (int k = 0; k < 6; k++) begin
            car = seq[k];
            tick(1);
        end
        car = 7'h20;
        tick(1);
        tests++;
        if (count !== 4'd2) begin fails++; $display("FAIL auto_count: got %0d want 2", count); end
        press(0, 1);
        tests++;
        if (obs !== expect_of(1, 0, 2)) begin fails++; $display("FAIL auto_step_ignored: got %h want %h", obs, expect_of(1, 0, 2)); end
        press(1, 0);
        tests++;
        if (state !== 2'd0 || cpu_start !== 1'b0) begin fails++; $display("FAIL auto_stop: got %h want state 0", obs); end
    endtask

    task automatic test_step();
        sw = 1'b1;
        tick(10);
        press(1, 0);
        tests++;
        if (obs !== expect_of(1, 1, 0)) begin fails++; $display("FAIL step_run: got %h want %h", obs, expect_of(1, 1, 0)); end
        press(0, 1);
        tests++;
        if (obs !== expect_of(2, 1, 0)) begin fails++; $display("FAIL step_armed: got %h want %h", obs, expect_of(2, 1, 0)); end
        car = 7'h00;
        tick(1);
        tests++;
        if (obs !== expect_of(1, 1, 1)) begin fails++; $display("FAIL step_consumed: got %h want %h", obs, expect_of(1, 1, 1)); end
        car = 7'h20;
        tick(1);
    endtask

    task automatic test_halt();
        halt = 1'b1;
        tick(1);
        tests++;
        if (obs !== expect_of(3, 1, 1)) begin fails++; $display("FAIL halt_enter: got %h want %h", obs, expect_of(3, 1, 1)); end
        halt = 1'b0;
        tick(3);
        tests++;
        if (obs !== expect_of(3, 1, 1)) begin fails++; $display("FAIL halt_hold: got %h want %h", obs, expect_of(3, 1, 1)); end
        press(1, 0);
        tests++;
        if (obs[9:4] !== 6'd0) begin fails++; $display("FAIL halt_exit: got %h want flags and state 0", obs); end
    endtask

    task automatic test_halt_beats_start();
        press(1, 0);
        press(0, 1);
        press(0, 1);
        tests++;
        if (obs !== expect_of(2, 1, 0)) begin fails++; $display("FAIL armed_no_queue: got %h want %h", obs, expect_of(2, 1, 0)); end
        btn_start = 1'b1;
        tick(6);
        tests++;
        if (state !== 2'd2) begin fails++; $display("FAIL pre_collision: got %0d want 2", state); end
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        tests++;
        if (obs !== expect_of(3, 1, 0)) begin fails++; $display("FAIL halt_beats_start: got %h want %h", obs, expect_of(3, 1, 0)); end
        tick(4);
        btn_start = 1'b0;
        tick(10);
        tests++;
        if (state !== 2'd3) begin fails++; $display("FAIL halt_persist: got %0d want 3", state); end
        press(1, 0);
    endtask

    task automatic test_wrap_and_reset();
        press(1, 0);
        for (int k = 0; k < 17; k++) fetch_once();
        tests++;
        if (obs !== expect_of(1, 1, 1)) begin fails++; $display("FAIL count_wrap: got %h want %h", obs, expect_of(1, 1, 1)); end
        press(0, 1);
        tests++;
        if (stim !== 1'b1) begin fails++; $display("FAIL pre_reset_armed: got %b want 1", stim); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 10'd0) begin fails++; $display("FAIL async_reset: got %h want %h", obs, 10'd0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
    endtask

    task automatic test_random();
        int  ms = 0, mc = 0, op;
        bit  mse = 0;
        bit  msw = sw;
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(5));
            case (op)
                0, 2: begin
                    press(1, op == 2);
                    if (ms == 0) begin ms = 1; mse = msw; mc = 0; end
                    else begin ms = 0; mse = 0; end
                end
                1: begin
                    press(0, 1);
                    if (ms == 1 && mse) ms = 2;
                end
                3: begin
                    fetch_once();
                    if (ms != 0) mc = mc + 1;
                    if (ms == 2) ms = 1;
                end
                4: begin
                    halt = 1'b1;
                    tick(1);
                    halt = 1'b0;
                    tick(1);
                    if (ms == 1 || ms == 2) ms = 3;
                end
                default: begin
                    sw = ~sw;
                    msw = sw;
                    tick(10);
                end
            endcase
            tests++;
            if (obs !== expect_of(ms, mse, mc)) begin
                fails++;
                $display("FAIL random op%0d n=%0d: got %h want %h", op, n, obs, expect_of(ms, mse, mc));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce();
        test_auto_fetch();
        test_step();
        test_halt();
        test_halt_beats_start();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
